// File: rtl/emio_gpio_debounce.sv
// emio_gpio_debounce: synchronizes and debounces slow board inputs, emits
// one-cycle rise/fall pulses and software-clearable sticky change flags.
// Ports:
//   clk            - single clock, rising edge
//   rstn           - asynchronous active-low reset
//   raw_in         - asynchronous raw pins
//   clr_req        - sticky-clear request (rising edge clears), synchronous to clk
//   db_out         - debounced level
//   rise_pulse     - one-cycle pulse when a db_out bit goes 0->1
//   fall_pulse     - one-cycle pulse when a db_out bit goes 1->0
//   changed_sticky - set on any accepted edge, held until cleared
//   irq            - OR of changed_sticky
module emio_gpio_debounce #(
    parameter int unsigned WIDTH           = 2,
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [WIDTH-1:0] raw_in,
    input  logic             clr_req,
    output logic [WIDTH-1:0] db_out,
    output logic [WIDTH-1:0] rise_pulse,
    output logic [WIDTH-1:0] fall_pulse,
    output logic [WIDTH-1:0] changed_sticky,
    output logic             irq
);

    localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [WIDTH-1:0] sync_q [SYNC_STAGES];
    logic [WIDTH-1:0] s;
    logic [CNT_W-1:0] cnt_q  [WIDTH];
    logic [CNT_W-1:0] cnt_d  [WIDTH];
    logic [WIDTH-1:0] db_d;
    logic [WIDTH-1:0] rise_d;
    logic [WIDTH-1:0] fall_d;
    logic [WIDTH-1:0] sticky_d;
    logic             clr_d;
    logic             clr_rise;

    // Synchronizer chain; s is the only consumer of raw_in.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int unsigned k = 0; k < SYNC_STAGES; k++) begin
                sync_q[k] <= '0;
            end
        end else begin
            sync_q[0] <= raw_in;
            for (int unsigned k = 1; k < SYNC_STAGES; k++) begin
                sync_q[k] <= sync_q[k-1];
            end
        end
    end

    assign s        = sync_q[SYNC_STAGES-1];
    assign clr_rise = clr_req & ~clr_d;

    // Per-bit debounce counters, edge pulses and sticky flags (next state).
    always_comb begin
        db_d     = db_out;
        rise_d   = '0;
        fall_d   = '0;
        sticky_d = changed_sticky;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            cnt_d[i] = '0;
            if (s[i] != db_out[i]) begin
                if (cnt_q[i] == CNT_MAX) begin
                    db_d[i]   = s[i];
                    rise_d[i] = s[i];
                    fall_d[i] = ~s[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_W'(1);
                end
            end
            // A registered pulse sets the flag and outranks a same-cycle clear.
            if (rise_pulse[i] | fall_pulse[i]) begin
                sticky_d[i] = 1'b1;
            end else if (clr_rise) begin
                sticky_d[i] = 1'b0;
            end
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int unsigned i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= '0;
            end
            db_out         <= '0;
            rise_pulse     <= '0;
            fall_pulse     <= '0;
            changed_sticky <= '0;
            clr_d          <= 1'b0;
        end else begin
            for (int unsigned i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
            db_out         <= db_d;
            rise_pulse     <= rise_d;
            fall_pulse     <= fall_d;
            changed_sticky <= sticky_d;
            clr_d          <= clr_req;
        end
    end

    // Pure OR of flops, so no combinational hazard from inputs.
    assign irq = |changed_sticky;

endmodule

// File: tb/tb_emio_gpio_debounce.sv
// Testbench for emio_gpio_debounce: directed scenarios plus randomized inputs,
// checked every cycle against a sample-history reference model.
module tb_emio_gpio_debounce;

    localparam int W    = 2;
    localparam int SYNC = 2;
    localparam int DC   = 8;

    logic         clk = 1'b0;
    logic         rstn;
    logic [W-1:0] raw_in;
    logic         clr_req;
    logic [W-1:0] db_out;
    logic [W-1:0] rise_pulse;
    logic [W-1:0] fall_pulse;
    logic [W-1:0] changed_sticky;
    logic         irq;

    int n_checks = 0;
    int n_fail   = 0;

    emio_gpio_debounce #(
        .WIDTH          (W),
        .SYNC_STAGES    (SYNC),
        .DEBOUNCE_CYCLES(DC)
    ) dut (
        .clk           (clk),
        .rstn          (rstn),
        .raw_in        (raw_in),
        .clr_req       (clr_req),
        .db_out        (db_out),
        .rise_pulse    (rise_pulse),
        .fall_pulse    (fall_pulse),
        .changed_sticky(changed_sticky),
        .irq           (irq)
    );

    always #5 clk = ~clk;

    // Reference model state: raw samples taken at each edge plus expected outputs.
    logic [W-1:0] hist [$];
    logic [W-1:0] m_db, m_rise, m_fall, m_sticky;
    logic         m_clr_d;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        hist.delete();
        for (int k = 0; k < DC + SYNC; k++) hist.push_back('0);
        m_db     = '0;
        m_rise   = '0;
        m_fall   = '0;
        m_sticky = '0;
        m_clr_d  = 1'b0;
    endtask

    // At an edge, the debounced level flips when the synchronized level seen
    // at each of the last DC edges differed from the current level. The
    // synchronized level seen at an edge is the raw sample SYNC edges older.
    task automatic model_step();
        logic [W-1:0] ndb, nsticky;
        int n;
        bit all_diff;
        hist.push_back(raw_in);
        if (hist.size() > DC + SYNC) void'(hist.pop_front());
        n = hist.size();
        for (int i = 0; i < W; i++) begin
            all_diff = 1'b1;
            for (int j = 0; j < DC; j++) begin
                if (hist[n - 1 - SYNC - j][i] == m_db[i]) all_diff = 1'b0;
            end
            ndb[i] = all_diff ? ~m_db[i] : m_db[i];
            if (m_rise[i] | m_fall[i]) nsticky[i] = 1'b1;
            else if (clr_req && !m_clr_d) nsticky[i] = 1'b0;
            else nsticky[i] = m_sticky[i];
        end
        m_rise   = ndb & ~m_db;
        m_fall   = ~ndb & m_db;
        m_db     = ndb;
        m_sticky = nsticky;
        m_clr_d  = clr_req;
    endtask

    task automatic compare_all();
        check_eq("db_out", 32'(db_out), 32'(m_db));
        check_eq("rise_pulse", 32'(rise_pulse), 32'(m_rise));
        check_eq("fall_pulse", 32'(fall_pulse), 32'(m_fall));
        check_eq("changed_sticky", 32'(changed_sticky), 32'(m_sticky));
        check_eq("irq", 32'(irq), 32'(|m_sticky));
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
        compare_all();
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) cycle();
    endtask

    // Async reset pulse applied between edges; outputs must clear at once.
    task automatic do_reset();
        rstn = 1'b0;
        #1;
        model_reset();
        compare_all();
        repeat (2) @(posedge clk);
        #1;
        compare_all();
        rstn = 1'b1;
    endtask

    task automatic pulse_clear();
        clr_req = 1'b1;
        cycle();
        clr_req = 1'b0;
        cycle();
    endtask

    initial begin
        rstn    = 1'b1;
        raw_in  = 2'b11;
        clr_req = 1'b0;
        model_reset();

        // 1: level high through reset, qualified exactly SYNC+DC edges after release
        #2;
        rstn = 1'b0;
        #1;
        compare_all();
        repeat (3) @(posedge clk);
        #1;
        compare_all();
        rstn = 1'b1;
        for (int k = 1; k <= SYNC + DC; k++) begin
            cycle();
            if (k == SYNC + DC - 1) check_eq("t1_db_before", 32'(db_out), 32'h0);
        end
        check_eq("t1_db_at", 32'(db_out), 32'h3);
        check_eq("t1_rise", 32'(rise_pulse), 32'h3);
        cycle();
        check_eq("t1_rise_once", 32'(rise_pulse), 32'h0);
        check_eq("t1_sticky", 32'(changed_sticky), 32'h3);
        check_eq("t1_irq", 32'(irq), 32'h1);

        // settle both bits low and clear flags
        raw_in = 2'b00;
        run(14);
        pulse_clear();
        check_eq("pre2_sticky", 32'(changed_sticky), 32'h0);

        // 2: a DC-1 cycle glitch is invisible
        begin
            logic [W-1:0] seen;
            seen = '0;
            raw_in = 2'b01;
            for (int k = 0; k < DC - 1; k++) begin
                cycle();
                seen |= db_out | rise_pulse | fall_pulse | changed_sticky;
            end
            raw_in = 2'b00;
            for (int k = 0; k < 15; k++) begin
                cycle();
                seen |= db_out | rise_pulse | fall_pulse | changed_sticky;
            end
            check_eq("t2_glitch", 32'(seen), 32'h0);
        end

        // 3: held rise then held fall on bit 0
        raw_in = 2'b01;
        run(SYNC + DC - 1);
        check_eq("t3_db_before", 32'(db_out), 32'h0);
        cycle();
        check_eq("t3_db_at", 32'(db_out), 32'h1);
        check_eq("t3_rise", 32'(rise_pulse), 32'h1);
        cycle();
        check_eq("t3_rise_once", 32'(rise_pulse), 32'h0);
        raw_in = 2'b00;
        run(SYNC + DC);
        check_eq("t3_fall", 32'(fall_pulse), 32'h1);
        cycle();
        check_eq("t3_fall_once", 32'(fall_pulse), 32'h0);

        // 4: held clear acts once; a later edge during the hold stays flagged
        raw_in = 2'b10;
        run(SYNC + DC + 2);
        check_eq("t4_sticky_pre", 32'(changed_sticky), 32'h3);
        clr_req = 1'b1;
        cycle();
        check_eq("t4_sticky_clr", 32'(changed_sticky), 32'h0);
        check_eq("t4_irq_clr", 32'(irq), 32'h0);
        raw_in = 2'b00;
        run(19);
        check_eq("t4_sticky_hold", 32'(changed_sticky), 32'h2);
        clr_req = 1'b0;
        cycle();

        // 5: fall pulse on bit 1 coincides with clear rise -> bit 1 survives
        raw_in = 2'b01;
        run(SYNC + DC + 2);
        raw_in = 2'b11;
        run(SYNC + DC + 2);
        check_eq("t5_sticky_pre", 32'(changed_sticky), 32'h3);
        raw_in = 2'b01;
        run(SYNC + DC);
        check_eq("t5_fall", 32'(fall_pulse), 32'h2);
        clr_req = 1'b1;
        cycle();
        check_eq("t5_sticky", 32'(changed_sticky), 32'h2);
        clr_req = 1'b0;
        cycle();

        // 6: reset in mid-count; re-qualification takes the full latency
        raw_in = 2'b11;
        run(SYNC + 5);
        do_reset();
        check_eq("t6_db_rst", 32'(db_out), 32'h0);
        run(SYNC + DC - 1);
        check_eq("t6_db_before", 32'(db_out), 32'h0);
        cycle();
        check_eq("t6_db_at", 32'(db_out), 32'h3);
        check_eq("t6_rise", 32'(rise_pulse), 32'h3);

        // randomized phase: bursty toggles, random clears, occasional reset
        for (int k = 0; k < 3000; k++) begin
            if ($urandom_range(0, 599) == 0) do_reset();
            for (int i = 0; i < W; i++) begin
                if ($urandom_range(0, 11) == 0) raw_in[i] = ~raw_in[i];
            end
            if ($urandom_range(0, 19) == 0) clr_req = ~clr_req;
            cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
